// File: rtl/cache_refill_controller.sv
// Blocking miss handler: serves hits from the cache, refills a 4-word block from memory on a miss.
// Optional macro CACHE_CRITICAL_WORD_FIRST_EN: fetch starts at the requested word, which is returned early.
module cache_refill_controller #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic                      hit,
    input  logic [DATA_WIDTH-1:0]     cache_out,
    output logic                      mem_read,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      mem_valid,
    output logic                      cache_write,
    output logic [ADDR_WIDTH-3:0]     cache_block_addr,
    output logic [4*DATA_WIDTH-1:0]   cache_block,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        FILL    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   line_q [4];
    logic [DATA_WIDTH-1:0]   line_d [4];
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    cache_write_q, cache_write_d;
    logic                    busy_q, busy_d;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [1:0]              fetched_q, fetched_d;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        mem_read     = 1'b0;
        mem_address  = '0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        fetched_d    = fetched_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        data_out_d   = cache_out;
                        data_valid_d = 1'b1;
                    end else begin
                        addr_d  = address;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                        cnt_d     = address[1:0];
                        fetched_d = 2'd0;
`else
                        cnt_d   = 2'd0;
`endif
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[ADDR_WIDTH-1:2], cnt_q};
                if (mem_valid) begin
                    line_d[cnt_q] = mem_data;
                    cnt_d         = cnt_q + 2'd1;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                    // The requested word is the first one fetched; forward it straight to the CPU.
                    fetched_d = fetched_q + 2'd1;
                    if (cnt_q == addr_q[1:0]) begin
                        data_out_d   = mem_data;
                        data_valid_d = 1'b1;
                    end
                    if (fetched_q == 2'd3) begin
                        state_d = FILL;
                    end
`else
                    if (cnt_q == 2'd3) begin
                        state_d = FILL;
                    end
`endif
                end
            end
            FILL: begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                state_d = IDLE;
`else
                // Registered outputs are loaded on entry so data_valid is high during RESPOND.
                state_d      = RESPOND;
                data_out_d   = line_q[addr_q[1:0]];
                data_valid_d = 1'b1;
`endif
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cache_write_d = (state_d == FILL);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            cache_write_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= '0;
            end
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            fetched_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            cache_write_q <= cache_write_d;
            busy_q        <= busy_d;
            for (int i = 0; i < 4; i++) begin
                line_q[i] <= line_d[i];
            end
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            fetched_q     <= fetched_d;
`endif
        end
    end

    // The fill buffer itself is the block presented to the cache; cache_write qualifies it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_block
        assign cache_block[gi*DATA_WIDTH +: DATA_WIDTH] = line_q[gi];
    end

    assign cache_block_addr = addr_q[ADDR_WIDTH-1:2];
    assign cache_write      = cache_write_q;
    assign data_out         = data_out_q;
    assign data_valid       = data_valid_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Self-checking bench for cache_refill_controller: transaction-level expectations checked every cycle.
module tb_cache_refill_controller;
    localparam int AW = 15;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, req, hit, mem_valid;
    logic [AW-1:0]   address;
    logic [DW-1:0]   cache_out, mem_data;
    logic            mem_read, cache_write, data_valid, busy;
    logic [AW-1:0]   mem_address;
    logic [AW-3:0]   cache_block_addr;
    logic [4*DW-1:0] cache_block;
    logic [DW-1:0]   data_out;

    always #5 clk = ~clk;

    cache_refill_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .address(address), .hit(hit),
        .cache_out(cache_out), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data(mem_data), .mem_valid(mem_valid), .cache_write(cache_write),
        .cache_block_addr(cache_block_addr), .cache_block(cache_block),
        .data_out(data_out), .data_valid(data_valid), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs, written by the transaction tasks for the cycle being driven.
    bit              chk_en = 1'b0;
    logic            exp_mr, exp_cw, exp_dv, exp_busy;
    logic [AW-1:0]   exp_ma;
    logic [AW-3:0]   exp_cba;
    logic [4*DW-1:0] exp_cb;
    logic [DW-1:0]   exp_do;
    int              t0, dv_cyc, cw_cyc, cw_cnt;

    task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_read", {127'd0, mem_read}, {127'd0, exp_mr});
            if (exp_mr) chk("mem_address", {113'd0, mem_address}, {113'd0, exp_ma});
            chk("cache_write", {127'd0, cache_write}, {127'd0, exp_cw});
            chk("data_valid", {127'd0, data_valid}, {127'd0, exp_dv});
            chk("busy", {127'd0, busy}, {127'd0, exp_busy});
            if (exp_cw) begin
                chk("cache_block_addr", {115'd0, cache_block_addr}, {115'd0, exp_cba});
                chk("cache_block", cache_block, exp_cb);
            end
            if (exp_dv) chk("data_out", {96'd0, data_out}, {96'd0, exp_do});
            if (data_valid) dv_cyc = cyc - t0;
            if (cache_write) begin
                cw_cyc = cyc - t0;
                cw_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_mr = 1'b0; exp_cw = 1'b0; exp_dv = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0; hit = $urandom_range(0, 1);
            mem_valid = 1'(($urandom % 2));
            mem_data = $urandom;
            idle_exp();
            tick();
        end
        mem_valid = 1'b0;
    endtask

    task automatic do_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = 1'b1; hit = 1'b1; address = a; cache_out = d;
        mem_valid = 1'(($urandom % 2)); mem_data = $urandom;
        idle_exp();
        t0 = cyc; dv_cyc = -1; cw_cnt = 0;
        tick();
        req = 1'b0; hit = 1'b0; mem_valid = 1'b0; cache_out = $urandom;
        exp_dv = 1'b1; exp_do = d;
        tick();
        idle_exp();
        $display("hit  addr=%04h data=%08h", a, d);
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input logic [DW-1:0] words [4],
                           input int waits [4], input bit stray);
        int w;
        req = 1'b1; hit = 1'b0; address = a;
        mem_valid = 1'(($urandom % 2)); mem_data = $urandom;
        idle_exp();
        t0 = cyc; dv_cyc = -1; cw_cnt = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            w = (int'(a[1:0]) + k) % 4;
`else
            w = k;
`endif
            for (int j = 0; j <= waits[k]; j++) begin
                mem_valid = (j == waits[k]);
                mem_data  = mem_valid ? words[w] : $urandom;
                exp_mr = 1'b1; exp_ma = {a[AW-1:2], w[1:0]};
                exp_busy = 1'b1; exp_cw = 1'b0; exp_dv = 1'b0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                if (k == 1 && j == 0) begin
                    exp_dv = 1'b1; exp_do = words[a[1:0]];
                end
`endif
                if (stray && k == 2 && j == 0) begin
                    req = 1'b1; hit = 1'b1; address = 15'h0100; cache_out = $urandom;
                end else begin
                    req = 1'b0; hit = 1'b0; address = $urandom;
                end
                tick();
            end
        end
        req = 1'b0; hit = 1'b0; mem_valid = 1'b0;
        exp_mr = 1'b0; exp_cw = 1'b1; exp_cba = a[AW-1:2];
        exp_cb = {words[3], words[2], words[1], words[0]};
        exp_busy = 1'b1; exp_dv = 1'b0;
        tick();
`ifndef CACHE_CRITICAL_WORD_FIRST_EN
        exp_cw = 1'b0; exp_dv = 1'b1; exp_do = words[a[1:0]]; exp_busy = 1'b1;
        tick();
`endif
        idle_exp();
        $display("miss addr=%04h words=%08h,%08h,%08h,%08h waits=%0d,%0d,%0d,%0d stray=%0d",
                 a, words[0], words[1], words[2], words[3], waits[0], waits[1], waits[2], waits[3], stray);
    endtask

    logic [DW-1:0] wd [4];
    int            wt [4];

    initial begin
        rst = 1'b1; req = 1'b0; hit = 1'b0; address = '0; cache_out = '0;
        mem_valid = 1'b0; mem_data = '0;
        idle_exp();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_data_out", {96'd0, data_out}, 128'd0);
        chk("reset_cache_block", cache_block, 128'd0);
        chk("reset_block_addr", {115'd0, cache_block_addr}, 128'd0);
        chk("reset_mem_address", {113'd0, mem_address}, 128'd0);

        // Reset in the second FETCH cycle of a miss to 0x0005; a late mem_valid must be ignored.
        req = 1'b1; hit = 1'b0; address = 15'h0005; idle_exp();
        tick();
        req = 1'b0; mem_valid = 1'b0;
        exp_mr = 1'b1; exp_busy = 1'b1;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        exp_ma = 15'h0005;
`else
        exp_ma = 15'h0004;
`endif
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; idle_exp(); mem_valid = 1'b1; mem_data = 32'h5555_5555;
        tick();
        mem_valid = 1'b0;
        tick();
        chk("abandoned_fill_buffer", cache_block, 128'd0);
        $display("reset mid-fetch addr=0005");

        do_hit(15'h0123, 32'hDEADBEEF);
        idle_cycles(1);

        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wt = '{0, 0, 0, 0};
        do_miss(15'h0046, wd, wt, 1'b0);
        chk("zw_cw_cycle", 128'(cw_cyc), 128'd5);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        chk("zw_dv_cycle", 128'(dv_cyc), 128'd2);
`else
        chk("zw_dv_cycle", 128'(dv_cyc), 128'd6);
`endif
        chk("zw_data_out", {96'd0, data_out}, 128'hA2);
        chk("zw_block_addr", {115'd0, cache_block_addr}, 128'h0011);
        chk("zw_block", cache_block, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        wt = '{2, 2, 2, 2};
        do_miss(15'h0046, wd, wt, 1'b0);
        chk("ws_cw_cycle", 128'(cw_cyc), 128'd13);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        chk("ws_dv_cycle", 128'(dv_cyc), 128'd4);
`else
        chk("ws_dv_cycle", 128'(dv_cyc), 128'd14);
`endif
        chk("ws_cw_pulses", 128'(cw_cnt), 128'd1);

        // A hit request while busy is dropped; the next one after IDLE is serviced.
        wd = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
        wt = '{1, 0, 1, 0};
        do_miss(15'h0201, wd, wt, 1'b1);
        do_hit(15'h0100, 32'hCAFE_F00D);

        for (int n = 0; n < 40; n++) begin
            idle_cycles($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                do_hit(AW'($urandom), $urandom);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    wd[i] = $urandom;
                    wt[i] = $urandom_range(0, 3);
                end
                do_miss(AW'($urandom), wd, wt, 1'($urandom_range(0, 1)));
                chk("rand_cw_pulses", 128'(cw_cnt), 128'd1);
            end
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
